stream_dword_packer: RTL



---
 rtl/stream_dword_packer.sv | 82 ++++++++
 1 files changed

// File: rtl/stream_dword_packer.sv
// Packs a byte stream little-endian into LANES-byte words with keep/last, one-word output register.
// Latency: word visible one cycle after its final byte is accepted; upstream stalls whenever the held word is not taken.
module stream_dword_packer #(
    parameter int          LANES     = 4,
    parameter logic [7:0]  PAD_BYTE  = 8'h00,
    parameter int          CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [8*LANES-1:0]    m_data,
    output logic [LANES-1:0]      m_keep,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int              IW       = $clog2(LANES);
    localparam logic [IW-1:0]   LAST_IDX = IW'(LANES - 1);

    logic [IW-1:0]        idx;
    logic [8*LANES-1:0]   acc;
    logic [8*LANES-1:0]   word_nxt;
    logic [LANES-1:0]     keep_nxt;
    logic                 accept;
    logic                 complete;

    assign s_ready  = reset_n && (!m_valid || m_ready);
    assign accept   = s_valid && s_ready;
    assign complete = accept && ((idx == LAST_IDX) || s_last);

    // Untouched lanes above idx still hold PAD_BYTE from the last refill.
    always_comb begin
        word_nxt = acc;
        keep_nxt = '0;
        for (int k = 0; k < LANES; k++) begin
            if (IW'(k) == idx)
                word_nxt[8*k +: 8] = s_data;
            keep_nxt[k] = (IW'(k) <= idx);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx        <= '0;
            acc        <= {LANES{PAD_BYTE}};
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
            m_last     <= 1'b0;
            word_count <= '0;
        end else begin
            if (accept) begin
                if (complete) begin
                    idx <= '0;
                    acc <= {LANES{PAD_BYTE}};
                end else begin
                    idx <= idx + 1'b1;
                    acc <= word_nxt;
                end
            end

            // A completion can only occur when the output slot is free or being drained this cycle.
            if (complete) begin
                m_valid <= 1'b1;
                m_data  <= word_nxt;
                m_keep  <= keep_nxt;
                m_last  <= s_last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end

            if (m_valid && m_ready)
                word_count <= word_count + 1'b1;
        end
    end

endmodule
